// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/subtract datapath.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  INF_EXP = 8'hFF;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, RESP} state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
  } fp_unp_t;

  // Denormals carry no hidden bit and are flushed to a signed zero here.
  function automatic fp_unp_t fp_unpack(input logic [31:0] f, input logic flip);
    fp_unp_t u;
    u.sign = f[31] ^ flip;
    u.exp  = f[30:23];
    u.sig  = (f[30:23] == '0) ? '0 : {1'b1, f[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// 28-bit leading-zero counter; an all-zero input reports 28.
module fp_lzc (
  input  logic [27:0] din,
  output logic [4:0]  cnt
);

  // Scan upward so the most significant set bit decides the count.
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (din[i]) cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract, one operation in flight.
//
// state | meaning
// IDLE  | ready for a new operation, operands captured on accept
// ALIGN | unpack, special-case bypass, swap and align smaller operand
// ADD   | add or subtract aligned significands
// NORM  | normalise via carry shift or leading-zero shift
// ROUND | round to nearest even, range checks, result staged
// RESP  | present result (o_valid rises one cycle in), hold until taken
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_fp1,
  input  logic [31:0] i_fp2,
  input  logic        i_op,
  output logic        o_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_fp,
  output logic [3:0]  o_flags
);
  import fp_pkg::*;

  localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);

  state_t state_q, state_d;

  logic [31:0] a_q, b_q;
  logic        op_q;

  fp_unp_t          ua, ub;
  logic             a_nan, b_nan, a_inf, b_inf, a_ge;
  logic             big_sign;
  logic [EXP_W-1:0] big_exp, sml_exp, diff;
  logic [MAN_W:0]   big_sig, sml_sig;
  logic [4:0]       sh;
  logic [26:0]      sml_ext, sml_shr, sml_mask;
  logic             byp_d;
  logic [31:0]      byp_fp_d;
  logic [3:0]       byp_flags_d;

  logic             sign_q, eff_sub_q, zneg_q, byp_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W:0]   big_sig_q;
  logic [26:0]      sml_q;
  logic [31:0]      byp_fp_q;
  logic [3:0]       byp_flags_q;

  logic [27:0]      big_ext, sum_d, sum_q;

  logic [4:0]         lz;
  logic [26:0]        shl, nrm_d, nrm_q;
  logic signed [9:0]  nexp_d, nexp_q;
  logic               zero_q;

  logic               rup;
  logic [24:0]        mant_rnd;
  logic signed [9:0]  exp_r;
  logic [MAN_W-1:0]   man_r;
  logic [31:0]        res_fp_d, res_fp_q;
  logic [3:0]         res_flags_d, res_flags_q;

  fp_lzc u_lzc (
    .din (sum_q),
    .cnt (lz)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; fixed one-cycle stages keep latency constant.
  always_comb begin
    state_d    = state_q;
    o_in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        o_in_ready = 1'b1;
        if (i_valid) state_d = ALIGN;
      end
      ALIGN: state_d = ADD;
      ADD:   state_d = NORM;
      NORM:  state_d = ROUND;
      ROUND: state_d = RESP;
      RESP:  if (o_valid && i_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Unpack, classify specials, order by magnitude and align the smaller operand.
  always_comb begin
    ua       = fp_unpack(a_q, 1'b0);
    ub       = fp_unpack(b_q, op_q);
    a_nan    = (a_q[30:23] == INF_EXP) && (a_q[22:0] != '0);
    b_nan    = (b_q[30:23] == INF_EXP) && (b_q[22:0] != '0);
    a_inf    = (a_q[30:23] == INF_EXP) && (a_q[22:0] == '0);
    b_inf    = (b_q[30:23] == INF_EXP) && (b_q[22:0] == '0);
    a_ge     = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
    big_sign = a_ge ? ua.sign : ub.sign;
    big_exp  = a_ge ? ua.exp  : ub.exp;
    big_sig  = a_ge ? ua.sig  : ub.sig;
    sml_exp  = a_ge ? ub.exp  : ua.exp;
    sml_sig  = a_ge ? ub.sig  : ua.sig;
    diff     = big_exp - sml_exp;
    sh       = (diff > 8'd27) ? 5'd27 : diff[4:0];
    sml_ext  = {sml_sig, 3'b000};
    sml_shr  = sml_ext >> sh;
    sml_mask = (27'd1 << sh) - 27'd1;
    byp_d       = 1'b0;
    byp_fp_d    = '0;
    byp_flags_d = '0;
    if (a_nan || b_nan) begin
      byp_d = 1'b1;
      byp_fp_d = QNAN;
      byp_flags_d[FLAG_INVALID] = 1'b1;
    end else if (a_inf && b_inf && (ua.sign != ub.sign)) begin
      byp_d = 1'b1;
      byp_fp_d = QNAN;
      byp_flags_d[FLAG_INVALID] = 1'b1;
    end else if (a_inf) begin
      byp_d = 1'b1;
      byp_fp_d = {ua.sign, INF_EXP, 23'd0};
    end else if (b_inf) begin
      byp_d = 1'b1;
      byp_fp_d = {ub.sign, INF_EXP, 23'd0};
    end
  end

  // Magnitude add/subtract; |big| >= |small| so the difference never goes negative.
  always_comb begin
    big_ext = {1'b0, big_sig_q, 3'b000};
    sum_d   = eff_sub_q ? (big_ext - {1'b0, sml_q}) : (big_ext + {1'b0, sml_q});
  end

  // Bring the leading one to bit 26; sticky is kept in bit 0 on the right shift.
  always_comb begin
    shl = sum_q[26:0] << (lz - 5'd1);
    if (sum_q[27]) begin
      nrm_d  = {sum_q[27:2], sum_q[1] | sum_q[0]};
      nexp_d = $signed({2'b00, exp_q}) + 10'sd1;
    end else begin
      nrm_d  = shl;
      nexp_d = $signed({2'b00, exp_q}) - $signed({5'b00000, lz - 5'd1});
    end
  end

  // Round to nearest even, then resolve bypass, zero, overflow and flush-to-zero.
  always_comb begin
    rup         = nrm_q[2] & (nrm_q[1] | nrm_q[0] | nrm_q[3]);
    mant_rnd    = {1'b0, nrm_q[26:3]} + {24'd0, rup};
    exp_r       = nexp_q + $signed({9'd0, mant_rnd[24]});
    man_r       = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
    res_fp_d    = {sign_q, exp_r[EXP_W-1:0], man_r};
    res_flags_d = '0;
    if (byp_q) begin
      res_fp_d    = byp_fp_q;
      res_flags_d = byp_flags_q;
    end else if (zero_q) begin
      res_fp_d = {zneg_q, 31'd0};
    end else if (exp_r >= EXP_TOP) begin
      res_fp_d = {sign_q, INF_EXP, 23'd0};
      res_flags_d[FLAG_OVERFLOW] = 1'b1;
      res_flags_d[FLAG_INEXACT]  = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      res_fp_d = {sign_q, 31'd0};
      res_flags_d[FLAG_UNDERFLOW] = 1'b1;
      res_flags_d[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_flags_d[FLAG_INEXACT] = nrm_q[2] | nrm_q[1] | nrm_q[0];
    end
  end

  // Stage registers, each loaded only in the state that produces it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0; b_q <= '0; op_q <= 1'b0;
      sign_q <= 1'b0; exp_q <= '0; big_sig_q <= '0; sml_q <= '0;
      eff_sub_q <= 1'b0; zneg_q <= 1'b0;
      byp_q <= 1'b0; byp_fp_q <= '0; byp_flags_q <= '0;
      sum_q <= '0; nrm_q <= '0; nexp_q <= '0; zero_q <= 1'b0;
      res_fp_q <= '0; res_flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          a_q <= i_fp1; b_q <= i_fp2; op_q <= i_op;
        end
        ALIGN: begin
          sign_q      <= big_sign;
          exp_q       <= big_exp;
          big_sig_q   <= big_sig;
          sml_q       <= {sml_shr[26:1], sml_shr[0] | (|(sml_ext & sml_mask))};
          eff_sub_q   <= ua.sign ^ ub.sign;
          zneg_q      <= ua.sign & ub.sign;
          byp_q       <= byp_d;
          byp_fp_q    <= byp_fp_d;
          byp_flags_q <= byp_flags_d;
        end
        ADD:   sum_q <= sum_d;
        NORM: begin
          nrm_q  <= nrm_d;
          nexp_q <= nexp_d;
          zero_q <= (sum_q == '0);
        end
        ROUND: begin
          res_fp_q    <= res_fp_d;
          res_flags_q <= res_flags_d;
        end
        default: ;
      endcase
    end
  end

  // Output register: raise valid one cycle into RESP, drop it on handoff.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_fp    <= '0;
      o_flags <= '0;
    end else if (state_q == RESP) begin
      if (!o_valid) begin
        o_valid <= 1'b1;
        o_fp    <= res_fp_q;
        o_flags <= res_flags_q;
      end else if (i_out_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
